// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: one single-port RAM shared by the 1080p block
// scan-out and a host port. Scan-out reads always win the slot.
module vga_fb_arbiter #(
   parameter int H_BLOCKS = 240,
   parameter int AW       = 15,
   parameter int DW       = 8
) (
   input  logic          CLOCK150,
   input  logic          RESET_N,
   input  logic [11:0]   x,
   input  logic [10:0]   y,
   output logic [DW-1:0] pix_data,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_ack,
   output logic [DW-1:0] host_rdata,
   output logic          host_rvalid,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   localparam logic [11:0]   X_LAST  = 12'd2543;
   localparam logic [11:0]   X_PREF  = 12'd2536;
   localparam logic [11:0]   X_SLOTS = 12'd1912;
   localparam logic [11:0]   X_VIS   = 12'd1920;
   localparam logic [10:0]   Y_LAST  = 11'd1115;
   localparam logic [10:0]   Y_VIS   = 11'd1080;
   localparam logic [AW-1:0] HB      = AW'(H_BLOCKS);

   typedef enum logic [1:0] {
      H_IDLE,
      H_GRANT,
      H_BLOCKED
   } hstate_t;

   typedef enum logic [1:0] {
      K_NONE,
      K_DISP,
      K_HOST
   } kind_t;

   hstate_t       state;
   hstate_t       state_nx;
   logic          grant;
   kind_t         k1;
   kind_t         k2;
   logic [DW-1:0] pix_next;

   logic [10:0]   ny;
   logic [11:0]   nx;
   logic [10:0]   nline;
   logic          disp_slot;
   logic          pref_slot;
   logic          slot;
   logic          vis;
   logic [AW-1:0] disp_addr;
   logic [AW-1:0] pref_addr;
   logic [AW-1:0] slot_addr;

   always_comb begin
      ny        = (y == Y_LAST) ? 11'd0 : y + 11'd1;
      nx        = (x == X_LAST) ? 12'd0 : x + 12'd1;
      nline     = (x == X_LAST) ? ny : y;
      vis       = (nx < X_VIS) && (nline < Y_VIS);
      disp_slot = (x[2:0] == 3'd0) && (x < X_SLOTS) && (y < Y_VIS);
      pref_slot = (x == X_PREF) && (ny < Y_VIS);
      slot      = disp_slot || pref_slot;
      // Each display slot fetches the block after the one now on screen.
      disp_addr = AW'(y[10:3]) * HB + AW'(x[11:3]) + AW'(1);
      pref_addr = AW'(ny[10:3]) * HB;
      slot_addr = disp_slot ? disp_addr : pref_addr;
   end

   always_ff @(posedge CLOCK150 or negedge RESET_N) begin
      if (!RESET_N) state <= H_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      grant    = 1'b0;
      unique case (state)
         H_IDLE: begin
            if (host_req) begin
               if (slot) begin
                  state_nx = H_BLOCKED;
               end else begin
                  state_nx = H_GRANT;
                  grant    = 1'b1;
               end
            end
         end
         H_GRANT: state_nx = H_IDLE;
         H_BLOCKED: begin
            if (!slot) begin
               state_nx = H_GRANT;
               grant    = 1'b1;
            end
         end
         default: state_nx = H_IDLE;
      endcase
   end

   always_ff @(posedge CLOCK150 or negedge RESET_N) begin
      if (!RESET_N) begin
         pix_data    <= '0;
         pix_next    <= '0;
         host_ack    <= 1'b0;
         host_rdata  <= '0;
         host_rvalid <= 1'b0;
         ram_addr    <= '0;
         ram_we      <= 1'b0;
         ram_wdata   <= '0;
         k1          <= K_NONE;
         k2          <= K_NONE;
      end else begin
         host_ack <= grant;
         k2       <= k1;
         if (slot) begin
            ram_addr <= slot_addr;
            ram_we   <= 1'b0;
            k1       <= K_DISP;
         end else if (grant) begin
            ram_addr <= host_addr;
            ram_we   <= host_we;
            k1       <= host_we ? K_NONE : K_HOST;
            if (host_we) ram_wdata <= host_wdata;
         end else begin
            ram_we <= 1'b0;
            k1     <= K_NONE;
         end
         host_rvalid <= (k2 == K_HOST);
         if (k2 == K_HOST) host_rdata <= ram_rdata;
         if (k2 == K_DISP) pix_next <= ram_rdata;
         if (x[2:0] == 3'd7) pix_data <= vis ? pix_next : '0;
      end
   end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: synchronous RAM model, host-read
// scoreboard and directed scan-out sweeps.
module tb_vga_fb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] x;
   logic [10:0] y;
   logic [7:0]  pix_data;
   logic        host_req;
   logic        host_we;
   logic [14:0] host_addr;
   logic [7:0]  host_wdata;
   logic        host_ack;
   logic [7:0]  host_rdata;
   logic        host_rvalid;
   logic [14:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc_n  = 0;

   typedef struct {
      int         due;
      logic [7:0] data;
   } rd_t;
   rd_t sb[$];

   logic [7:0] mem [0:32767];
   bit         vld [0:32767];

   vga_fb_arbiter dut (
      .CLOCK150   (clk),
      .RESET_N    (rst_n),
      .x          (x),
      .y          (y),
      .pix_data   (pix_data),
      .host_req   (host_req),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_ack   (host_ack),
      .host_rdata (host_rdata),
      .host_rvalid(host_rvalid),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input logic [14:0] a);
      case (a)
         15'd241: return 8'h5A;
         15'd240: return 8'h33;
         default: return a[7:0] ^ {1'b0, a[14:8]} ^ 8'hA5;
      endcase
   endfunction

   always @(posedge clk) begin
      cyc_n <= cyc_n + 1;
      if (ram_we) begin
         mem[ram_addr] <= ram_wdata;
         vld[ram_addr] <= 1'b1;
      end
      ram_rdata <= vld[ram_addr] ? mem[ram_addr] : pat(ram_addr);
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (host_rvalid) begin
         if (sb.size() == 0) begin
            chk("rvalid_spurious", host_rvalid, 0);
         end else begin
            rd_t e;
            e = sb.pop_front();
            chk("rd_data", host_rdata, e.data);
            chk("rd_cycle", cyc_n, e.due);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
      if (x == 12'd2543) begin
         x = 12'd0;
         y = (y == 11'd1115) ? 11'd0 : y + 11'd1;
      end else begin
         x = x + 12'd1;
      end
   endtask

   task automatic run_to(input int xe);
      while (x != 12'(xe)) cyc();
   endtask

   task automatic jump(input int xv, input int yv);
      x = 12'(xv);
      y = 11'(yv);
   endtask

   task automatic rst_chk();
      chk("rst_pix", pix_data, 0);
      chk("rst_ack", host_ack, 0);
      chk("rst_rdata", host_rdata, 0);
      chk("rst_rvalid", host_rvalid, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_wdata", ram_wdata, 0);
   endtask

   // For reads, d is the data the bench expects back.
   task automatic host_op(input logic we, input logic [14:0] a,
                          input logic [7:0] d, input int wait_exp);
      int w;
      w          = 0;
      host_req   = 1'b1;
      host_we    = we;
      host_addr  = a;
      host_wdata = d;
      do begin
         cyc();
         w++;
      end while (!host_ack && w < 6);
      chk("ack_wait", w, wait_exp);
      if (host_ack) begin
         chk("ack_we", ram_we, we);
         chk("ack_addr", ram_addr, a);
         if (we) chk("ack_wdata", ram_wdata, d);
         else    sb.push_back('{due: cyc_n + 2, data: d});
      end
      host_req = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      host_req   = 1'b0;
      host_we    = 1'b0;
      host_addr  = '0;
      host_wdata = '0;
      jump(0, 10);
      repeat (3) @(posedge clk);
      #1;
      rst_chk();
      rst_n = 1'b1;

      cyc();
      chk("disp_addr", ram_addr, 241);
      chk("disp_we", ram_we, 0);
      run_to(8);
      chk("pix_x8", pix_data, 8'h5A);
      run_to(15);
      chk("pix_x15", pix_data, 8'h5A);

      jump(2530, 7);
      run_to(2537);
      chk("pref_addr", ram_addr, 240);
      chk("pref_we", ram_we, 0);
      run_to(0);
      chk("pref_pix0", pix_data, 8'h33);
      run_to(7);
      chk("pref_pix7", pix_data, 8'h33);
      run_to(8);
      chk("line8_pix8", pix_data, pat(15'd241));

      jump(1900, 1079);
      run_to(1905);
      chk("last_addr", ram_addr, 32399);
      run_to(1912);
      chk("last_pix", pix_data, pat(15'd32399));
      run_to(1919);
      chk("last_pix_end", pix_data, pat(15'd32399));
      run_to(1920);
      chk("blank_pix", pix_data, 0);
      run_to(2537);
      chk("nopref_addr", ram_addr, 32399);
      chk("nopref_we", ram_we, 0);
      jump(2530, 1078);
      run_to(2537);
      chk("pref1078_addr", ram_addr, 32160);
      jump(2530, 1115);
      run_to(2537);
      chk("wrap_addr", ram_addr, 0);
      run_to(0);
      chk("wrap_y", y, 0);
      chk("wrap_pix", pix_data, pat(15'd0));

      jump(62, 20);
      run_to(64);
      host_op(1'b1, 15'h100, 8'hC3, 2);
      chk("wr_ack_x", x, 66);
      cyc();
      chk("wr_ack_drop", host_ack, 0);
      chk("wr_we_drop", ram_we, 0);

      jump(1998, 20);
      run_to(2000);
      host_op(1'b0, 15'h100, 8'hC3, 1);
      chk("rd_ack_x", x, 2001);
      run_to(2006);

      jump(2534, 20);
      run_to(2536);
      host_op(1'b0, 15'h123, pat(15'h123), 2);
      jump(2534, 1079);
      run_to(2536);
      host_op(1'b0, 15'h7FFF, pat(15'h7FFF), 1);
      jump(0, 30);
      run_to(3);
      host_op(1'b1, 15'h200, 8'h77, 1);
      run_to(10);
      host_op(1'b0, 15'h200, 8'h77, 1);
      run_to(20);

      jump(1998, 40);
      run_to(2000);
      host_req  = 1'b1;
      host_we   = 1'b0;
      host_addr = 15'd5;
      cyc();
      chk("rst_rd_ack", host_ack, 1);
      host_req = 1'b0;
      cyc();
      rst_n = 1'b0;
      #1;
      rst_chk();
      cyc();
      rst_n = 1'b1;
      repeat (6) begin
         cyc();
         chk("rst_no_rvalid", host_rvalid, 0);
      end

      jump(0, 50);
      cyc();
      rst_n = 1'b0;
      #1;
      cyc();
      rst_n = 1'b1;
      run_to(8);
      chk("rst_pix_next", pix_data, 0);
      run_to(16);
      chk("resume_pix", pix_data, pat(15'd1442));

      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
